// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: writeback source select, load funct3 encodings,
// and helpers that classify load widths.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_MEM  = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic f3_is_byte(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LBU);
  endfunction

  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

  // Reserved encodings (011/110/111) behave as LW everywhere.
  function automatic logic f3_is_word(input logic [2:0] f3);
    return !f3_is_byte(f3) && !f3_is_half(f3);
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extension. The addressed byte arrives in the top byte lane, so narrow
// loads take the most-significant bits and sign/zero-extend them.
module load_ext
  import riscv_pkg::*;
#(
  parameter int unsigned Width = XLEN_DEFAULT
) (
  input  logic [2:0]       funct3_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{(Width - 8){data_i[Width-1]}}, data_i[Width-1 -: 8]};
      F3_LBU:  data_o = {{(Width - 8){1'b0}}, data_i[Width-1 -: 8]};
      F3_LH:   data_o = {{(Width - 16){data_i[Width-1]}}, data_i[Width-1 -: 16]};
      F3_LHU:  data_o = {{(Width - 16){1'b0}}, data_i[Width-1 -: 16]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback source mux, register-file
// write port, misaligned-load flag and retired-instruction counter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [1:0]       wbSel_i,
  input  logic             regWEn_i,
  input  logic [4:0]       rd_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  alu_i,
  input  logic [XLEN-1:0]  mem_data_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_rd_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] instret_o
);

  logic             valid_q, valid_d;
  wb_sel_e          wb_sel_q;
  logic             reg_wen_q;
  logic [4:0]       rd_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  mem_q;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  load_data;

  // Flush and stall both yield a bubble, so a held instruction is never written twice.
  assign valid_d   = valid_i & ~stall_i & ~flush_i;
  assign instret_d = instret_q + CNT_W'(valid_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      wb_sel_q  <= WB_MEM;
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      funct3_q  <= '0;
      pc_q      <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instret_q <= instret_d;
      if (valid_d) begin
        wb_sel_q  <= wb_sel_e'(wbSel_i);
        reg_wen_q <= regWEn_i;
        rd_q      <= rd_i;
        funct3_q  <= funct3_i;
        pc_q      <= pc_i;
        alu_q     <= alu_i;
        mem_q     <= mem_data_i;
      end
    end
  end

  load_ext #(
    .Width (XLEN)
  ) u_load_ext (
    .funct3_i (funct3_q),
    .data_i   (mem_q),
    .data_o   (load_data)
  );

  always_comb begin
    rf_we_o    = valid_q & reg_wen_q & (wb_sel_q != WB_NONE) & (rd_q != 5'd0);
    rf_rd_o    = valid_q ? rd_q : 5'd0;
    rf_wdata_o = '0;
    if (valid_q) begin
      unique case (wb_sel_q)
        WB_MEM:  rf_wdata_o = load_data;
        WB_ALU:  rf_wdata_o = alu_q;
        WB_PC4:  rf_wdata_o = pc_q + XLEN'(4);
        WB_NONE: rf_wdata_o = '0;
      endcase
    end
    misalign_o = valid_q & (wb_sel_q == WB_MEM) &
                 ((f3_is_half(funct3_q) & alu_q[0]) |
                  (f3_is_word(funct3_q) & (alu_q[1:0] != 2'b00)));
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset, load extension, writeback sources,
// rd=0 suppression, stall/flush bubbles and misaligned-load flagging.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  wbSel_i = 2'b00;
  logic        regWEn_i = 1'b0;
  logic [4:0]  rd_i = 5'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] alu_i = 32'd0;
  logic [31:0] mem_data_i = 32'd0;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic        misalign_o;
  logic [63:0] instret_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt = 0;
  int n_issued = 0;
  logic pend_we = 1'b0;

  wb_stage #(
    .XLEN  (32),
    .CNT_W (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .wbSel_i    (wbSel_i),
    .regWEn_i   (regWEn_i),
    .rd_i       (rd_i),
    .funct3_i   (funct3_i),
    .pc_i       (pc_i),
    .alu_i      (alu_i),
    .mem_data_i (mem_data_i),
    .rf_we_o    (rf_we_o),
    .rf_rd_o    (rf_rd_o),
    .rf_wdata_o (rf_wdata_o),
    .misalign_o (misalign_o),
    .instret_o  (instret_o)
  );

  always #5 clk = ~clk;

  // Sample the write enable mid-cycle; the write counts as committed only if
  // reset is still released at the following rising edge.
  always @(clk) begin
    if (!clk) begin
      pend_we = rf_we_o;
    end else begin
      if (pend_we && rst) wr_cnt++;
      pend_we = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic s, input logic f, input logic [1:0] sel,
                       input logic we, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] md);
    valid_i = v; stall_i = s; flush_i = f; wbSel_i = sel; regWEn_i = we; rd_i = rd;
    funct3_i = f3; pc_i = pc; alu_i = alu; mem_data_i = md;
    if (v && !s && !f) n_issued++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    n_issued = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total_cnt += 5;
    if (rf_we_o !== 1'b0) $display("FAIL reset_we: got %b expected 0", rf_we_o); else pass_cnt++;
    if (rf_rd_o !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", rf_rd_o); else pass_cnt++;
    if (rf_wdata_o !== 32'd0) $display("FAIL reset_wdata: got %h expected 0", rf_wdata_o);
    else pass_cnt++;
    if (misalign_o !== 1'b0) $display("FAIL reset_misalign: got %b expected 0", misalign_o);
    else pass_cnt++;
    if (instret_o !== 64'd0) $display("FAIL reset_instret: got %0d expected 0", instret_o);
    else pass_cnt++;
    #11 rst = 1'b1;
    @(posedge clk);
    #1;
    // A retires normally; B is dropped by reset while it is being written back.
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 5'd3, 3'd0, 32'h0, 32'h1111_1111, 32'h0);
    step();
    total_cnt++;
    if (rf_we_o !== 1'b1) $display("FAIL reset_pre_we: got %b expected 1", rf_we_o);
    else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 5'd4, 3'd0, 32'h0, 32'h2222_2222, 32'h0);
    step();
    #2 rst = 1'b0;
    #1;
    total_cnt += 4;
    if (rf_we_o !== 1'b0) $display("FAIL async_we: got %b expected 0", rf_we_o); else pass_cnt++;
    if (rf_rd_o !== 5'd0) $display("FAIL async_rd: got %0d expected 0", rf_rd_o); else pass_cnt++;
    if (rf_wdata_o !== 32'd0) $display("FAIL async_wdata: got %h expected 0", rf_wdata_o);
    else pass_cnt++;
    if (instret_o !== 64'd0) $display("FAIL async_instret: got %0d expected 0", instret_o);
    else pass_cnt++;
    idle();
    #10 rst = 1'b1;
    n_issued = 0;
    step();
    step();
    total_cnt += 2;
    if (instret_o !== 64'd0) $display("FAIL release_instret: got %0d expected 0", instret_o);
    else pass_cnt++;
    if (wr_cnt !== 1) $display("FAIL reset_dropped_write: got %0d writes expected 1", wr_cnt);
    else pass_cnt++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] exps [5] = '{32'hFFFF_FF8A, 32'h0000_008A, 32'hFFFF_8A12, 32'h0000_8A12,
                              32'h8A12_3456};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, f3s[i], 32'h0, 32'h0000_0200, 32'h8A12_3456);
      step();
      total_cnt += 3;
      if (rf_we_o !== 1'b1) $display("FAIL load%0d_we: got %b expected 1", i, rf_we_o);
      else pass_cnt++;
      if (rf_rd_o !== 5'd5) $display("FAIL load%0d_rd: got %0d expected 5", i, rf_rd_o);
      else pass_cnt++;
      if (rf_wdata_o !== exps[i])
        $display("FAIL load%0d_wdata: got %h expected %h", i, rf_wdata_o, exps[i]);
      else pass_cnt++;
    end
    idle();
    step();
  endtask

  task automatic test_sources();
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 5'd7, 3'd0, 32'h0000_0100, 32'h0, 32'h0);
    step();
    total_cnt += 2;
    if (rf_wdata_o !== 32'h0000_0104) $display("FAIL pc4_wdata: got %h expected 00000104",
                                               rf_wdata_o);
    else pass_cnt++;
    if (rf_rd_o !== 5'd7) $display("FAIL pc4_rd: got %0d expected 7", rf_rd_o); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 5'd9, 3'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    step();
    total_cnt++;
    if (rf_wdata_o !== 32'hDEAD_BEEF) $display("FAIL alu_wdata: got %h expected deadbeef",
                                               rf_wdata_o);
    else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 5'd8, 3'd0, 32'h0, 32'h1234_5678, 32'h0);
    step();
    total_cnt += 2;
    if (rf_we_o !== 1'b0) $display("FAIL none_we: got %b expected 0", rf_we_o); else pass_cnt++;
    if (rf_wdata_o !== 32'd0) $display("FAIL none_wdata: got %h expected 0", rf_wdata_o);
    else pass_cnt++;
    idle();
    step();
    total_cnt++;
    if (instret_o !== 64'(n_issued))
      $display("FAIL none_instret: got %0d expected %0d", instret_o, n_issued);
    else pass_cnt++;
  endtask

  task automatic test_rd0();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 5'd0, 3'd0, 32'h0, 32'h0000_00AA, 32'h0);
    step();
    total_cnt++;
    if (rf_we_o !== 1'b0) $display("FAIL rd0_we: got %b expected 0", rf_we_o); else pass_cnt++;
    idle();
    step();
    total_cnt++;
    if (instret_o !== 64'(n_issued))
      $display("FAIL rd0_instret: got %0d expected %0d", instret_o, n_issued);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w0;
    pulse_reset();
    w0 = wr_cnt;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 5'(i), 3'd0, 32'h0, 32'(i * 16), 32'h0);
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 5'd10, 3'd0, 32'h0, 32'h0000_0999, 32'h0);
    step();
    total_cnt++;
    if (rf_we_o !== 1'b0) $display("FAIL stall_we: got %b expected 0", rf_we_o); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 5'd11, 3'd0, 32'h0, 32'h0000_0888, 32'h0);
    step();
    total_cnt++;
    if (rf_we_o !== 1'b0) $display("FAIL flush_we: got %b expected 0", rf_we_o); else pass_cnt++;
    idle();
    step();
    step();
    total_cnt += 2;
    if (wr_cnt - w0 !== 3) $display("FAIL b2b_writes: got %0d expected 3", wr_cnt - w0);
    else pass_cnt++;
    if (instret_o !== 64'd3) $display("FAIL b2b_instret: got %0d expected 3", instret_o);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd6, 3'b010, 32'h0, 32'h0000_0102, 32'h0BAD_F00D);
    step();
    total_cnt += 2;
    if (misalign_o !== 1'b1) $display("FAIL misalign_set: got %b expected 1", misalign_o);
    else pass_cnt++;
    if (rf_we_o !== 1'b1) $display("FAIL misalign_we: got %b expected 1", rf_we_o);
    else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd6, 3'b010, 32'h0, 32'h0000_0104, 32'h0BAD_F00D);
    step();
    total_cnt += 2;
    if (misalign_o !== 1'b0) $display("FAIL aligned_clear: got %b expected 0", misalign_o);
    else pass_cnt++;
    if (rf_wdata_o !== 32'h0BAD_F00D) $display("FAIL aligned_wdata: got %h expected 0badf00d",
                                               rf_wdata_o);
    else pass_cnt++;
    idle();
    step();
    total_cnt++;
    if (misalign_o !== 1'b0) $display("FAIL misalign_idle: got %b expected 0", misalign_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sources();
    test_rd0();
    test_back_to_back();
    test_misalign();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
